// File: rtl/gc_stream_pkg.sv
// -----------------------------------------------------------------------------
// gc_stream_pkg
// Shared types for the GarbledCircuit output-stream collector.
//   - gc_class_e : entry classification carried on out_class
//   - TAG_*      : encodings of the 3-bit tag_t1 event field
//   - gc_entry_t : one buffered FIFO entry {class, cid, index, data}
// GC_S / GC_K must match the S / K parameters of the collector instance.
// -----------------------------------------------------------------------------
package gc_stream_pkg;

  localparam int GC_S = 10;   // index / cid width
  localparam int GC_K = 128;  // label / data width

  typedef enum logic [1:0] {
    GC_LABEL = 2'd0,
    GC_KEY   = 2'd1,
    GC_TABLE = 2'd2,
    GC_MASK  = 2'd3
  } gc_class_e;

  // Tags with bit 2 set are label events (bit0 -> lane 0, bit1 -> lane 1).
  localparam logic [2:0] TAG_IDLE  = 3'b000;
  localparam logic [2:0] TAG_KEY   = 3'b001;
  localparam logic [2:0] TAG_TABLE = 3'b010;
  localparam logic [2:0] TAG_MASK  = 3'b011;

  typedef struct packed {
    gc_class_e         cls;
    logic [GC_S-1:0]   cid;
    logic [GC_S-1:0]   index;
    logic [GC_K-1:0]   data;
  } gc_entry_t;

  // True when the class of an entry is enabled in the 4-bit class mask.
  function automatic logic class_enabled(input logic [3:0] en, input gc_class_e c);
    return en[c];
  endfunction

endpackage

// File: rtl/gc_dual_push_fifo.sv
// -----------------------------------------------------------------------------
// gc_dual_push_fifo
// Circular FIFO with two write lanes and one read port.
//   clk, rst        : clock, synchronous active-low reset
//   wr_en0/wr_data0 : first write lane (written ahead of lane 1)
//   wr_en1/wr_data1 : second write lane
//   rd_en           : pop request; ignored while empty
//   rd_data         : head entry, valid whenever occupancy != 0
//   occupancy       : number of stored entries (0..DEPTH)
// The caller guarantees that a push never exceeds the free space; this block
// does not re-check it. Head data is read combinationally so an entry is
// visible right after the edge that wrote it.
// -----------------------------------------------------------------------------
module gc_dual_push_fifo
  import gc_stream_pkg::*;
#(
  parameter int  DEPTH   = 16,
  parameter type entry_t = gc_entry_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en0,
  input  entry_t                   wr_data0,
  input  logic                     wr_en1,
  input  entry_t                   wr_data1,
  input  logic                     rd_en,
  output entry_t                   rd_data,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);

  entry_t         mem [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    occ_q, occ_d;
  logic [AW-1:0]  lane1_addr;
  logic           pop;

  always_comb begin
    pop        = rd_en && (occ_q != '0);
    // Lane 1 lands directly behind lane 0 when both write, otherwise at the
    // current write pointer, so the stored sequence has no holes.
    lane1_addr = wr_ptr_q + AW'(wr_en0);
    wr_ptr_d   = wr_ptr_q + AW'(wr_en0) + AW'(wr_en1);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    occ_d      = occ_q + (AW+1)'(wr_en0) + (AW+1)'(wr_en1) - (AW+1)'(pop);
  end

  // Storage has no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en0) mem[wr_ptr_q]  <= wr_data0;
    if (wr_en1) mem[lane1_addr] <= wr_data1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign rd_data   = mem[rd_ptr_q];
  assign occupancy = occ_q;

endmodule

// File: rtl/gc_stream_collector.sv
// -----------------------------------------------------------------------------
// gc_stream_collector
// Captures the tagged dual-word GarbledCircuit output stream, classifies each
// event into label / key / table / mask entries, buffers them and drains them
// over a valid/ready port.
//   clk, rst              : clock, synchronous active-low reset
//   tag_t1, cid           : event tag and garbling cycle id
//   index0_t1, index1_t1  : indices for the two data words
//   data0_t1, data1_t1    : the two data words
//   class_en              : per-class enable {mask, table, key, label}
//   out_valid/out_ready   : output handshake
//   out_class/out_cid/out_index/out_data : head entry
//   out_last              : head is the final entry of the run
//   done                  : run ended and buffer drained (sticky until reset)
//   overflow              : sticky, some entry was dropped for lack of space
//   drop_cnt              : saturating count of dropped entries
// S and K must equal GC_S and GC_K of gc_stream_pkg.
// -----------------------------------------------------------------------------
module gc_stream_collector
  import gc_stream_pkg::*;
#(
  parameter int S      = GC_S,
  parameter int K      = GC_K,
  parameter int CC     = 4,
  parameter int DEPTH  = 16,
  parameter int DROP_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        tag_t1,
  input  logic [S-1:0]      cid,
  input  logic [S-1:0]      index0_t1,
  input  logic [S-1:0]      index1_t1,
  input  logic [K-1:0]      data0_t1,
  input  logic [K-1:0]      data1_t1,
  input  logic [3:0]        class_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_class,
  output logic [S-1:0]      out_cid,
  output logic [S-1:0]      out_index,
  output logic [K-1:0]      out_data,
  output logic              out_last,
  output logic              done,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int AW = $clog2(DEPTH);

  gc_entry_t          lane0, lane1;
  logic               v0, v1;
  logic [1:0]         n_push;
  logic [AW:0]        occ;
  logic [AW:0]        free_slots;
  logic               end_evt, active, fits, accept;
  gc_entry_t          head;

  logic               done_seen_q, done_seen_d;
  logic               overflow_q, overflow_d;
  logic [DROP_W-1:0]  drop_q, drop_d;
  logic [DROP_W:0]    drop_sum;

  // ---------------------------------------------------------------------------
  // Event decode and class filter
  // ---------------------------------------------------------------------------
  always_comb begin
    lane0       = '0;
    lane1       = '0;
    v0          = 1'b0;
    v1          = 1'b0;
    lane0.cid   = cid;
    lane1.cid   = cid;
    lane0.data  = data0_t1;
    lane1.data  = data1_t1;
    lane0.cls   = GC_LABEL;
    lane1.cls   = GC_LABEL;
    if (tag_t1[2]) begin
      v0          = tag_t1[0];
      v1          = tag_t1[1];
      lane0.index = index0_t1;
      lane1.index = index1_t1;
    end else begin
      case (tag_t1)
        TAG_KEY: begin
          // Key words are addressed by position, not by the index inputs.
          v0          = 1'b1;
          v1          = 1'b1;
          lane0.cls   = GC_KEY;
          lane1.cls   = GC_KEY;
          lane0.index = '0;
          lane1.index = GC_S'(1);
        end
        TAG_TABLE: begin
          v0          = 1'b1;
          v1          = 1'b1;
          lane0.cls   = GC_TABLE;
          lane1.cls   = GC_TABLE;
          lane0.index = index0_t1;
          lane1.index = index1_t1;
        end
        TAG_MASK: begin
          v0          = 1'b1;
          lane0.cls   = GC_MASK;
          lane0.index = '0;
        end
        default: ;
      endcase
    end
    // Disabled classes vanish here, before any space or drop accounting.
    v0 = v0 && class_enabled(class_en, lane0.cls);
    v1 = v1 && class_enabled(class_en, lane1.cls);
  end

  // ---------------------------------------------------------------------------
  // Admission, overflow, drop counting and end-of-run tracking
  // ---------------------------------------------------------------------------
  always_comb begin
    end_evt     = (cid == S'(CC));
    // The end-of-run event itself is never stored.
    active      = !done_seen_q && !end_evt;
    n_push      = {1'b0, v0} + {1'b0, v1};
    // Space is judged on the occupancy at the start of the cycle; a pop in the
    // same cycle does not make room for this push.
    free_slots  = (AW+1)'(DEPTH) - occ;
    fits        = ((AW+1)'(n_push) <= free_slots);
    accept      = active && fits;

    done_seen_d = done_seen_q || end_evt;
    overflow_d  = overflow_q;
    drop_sum    = {1'b0, drop_q} + (DROP_W+1)'(n_push);
    drop_d      = drop_q;
    if (active && (n_push != 2'd0) && !fits) begin
      overflow_d = 1'b1;
      drop_d     = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      done_seen_q <= 1'b0;
      overflow_q  <= 1'b0;
      drop_q      <= '0;
    end else begin
      done_seen_q <= done_seen_d;
      overflow_q  <= overflow_d;
      drop_q      <= drop_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Entry buffer
  // ---------------------------------------------------------------------------
  gc_dual_push_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (gc_entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en0    (accept && v0),
    .wr_data0  (lane0),
    .wr_en1    (accept && v1),
    .wr_data1  (lane1),
    .rd_en     (out_ready),
    .rd_data   (head),
    .occupancy (occ)
  );

  assign out_valid = (occ != '0);
  assign out_class = head.cls;
  assign out_cid   = head.cid;
  assign out_index = head.index;
  assign out_data  = head.data;
  assign out_last  = done_seen_q && (occ == (AW+1)'(1)) && out_valid;
  assign done      = done_seen_q && (occ == '0);
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_gc_stream_collector.sv
// -----------------------------------------------------------------------------
// tb_gc_stream_collector
// Table-driven event vectors plus hand-written corner sequences; expected
// entries go into a scoreboard queue when an event is sampled and are compared
// against the output port every cycle the port is valid.
// -----------------------------------------------------------------------------
module tb_gc_stream_collector;

  localparam int S = 10, K = 128, CC = 4, DEPTH = 16, DROP_W = 16;
  localparam logic [1:0] C_LAB = 2'd0, C_KEY = 2'd1, C_TAB = 2'd2, C_MSK = 2'd3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [2:0]        tag_t1 = '0;
  logic [S-1:0]      cid = '0, index0_t1 = '0, index1_t1 = '0;
  logic [K-1:0]      data0_t1 = '0, data1_t1 = '0;
  logic [3:0]        class_en = 4'hF;
  logic              out_valid, out_ready = 1'b0;
  logic [1:0]        out_class;
  logic [S-1:0]      out_cid, out_index;
  logic [K-1:0]      out_data;
  logic              out_last, done, overflow;
  logic [DROP_W-1:0] drop_cnt;

  gc_stream_collector #(.S(S), .K(K), .CC(CC), .DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk(clk), .rst(rst), .tag_t1(tag_t1), .cid(cid),
    .index0_t1(index0_t1), .index1_t1(index1_t1),
    .data0_t1(data0_t1), .data1_t1(data1_t1), .class_en(class_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
    .out_cid(out_cid), .out_index(out_index), .out_data(out_data),
    .out_last(out_last), .done(done), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   tag;
    logic [S-1:0] cid, i0, i1;
    logic [K-1:0] d0, d1;
    logic [3:0]   cen;
    int           n;
    logic [1:0]   c0;  logic [S-1:0] x0i;  logic [K-1:0] x0d;
    logic [1:0]   c1;  logic [S-1:0] x1i;  logic [K-1:0] x1d;
  } ev_t;

  typedef struct {
    logic [1:0]   cls;
    logic [S-1:0] cid, idx;
    logic [K-1:0] data;
  } exp_t;

  exp_t sb[$];
  ev_t  cur;
  int   checks = 0, failures = 0;
  int   exp_drop = 0;
  bit   exp_ovf = 0, exp_done_seen = 0, pending_pop = 0, mon_en = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic ev_t mk(logic [2:0] tag, logic [S-1:0] c, i0, i1, logic [K-1:0] d0, d1,
                             logic [3:0] cen, int n, logic [1:0] c0, logic [S-1:0] x0i,
                             logic [K-1:0] x0d, logic [1:0] c1, logic [S-1:0] x1i,
                             logic [K-1:0] x1d);
    ev_t e;
    e.tag = tag; e.cid = c; e.i0 = i0; e.i1 = i1; e.d0 = d0; e.d1 = d1; e.cen = cen;
    e.n = n; e.c0 = c0; e.x0i = x0i; e.x0d = x0d; e.c1 = c1; e.x1i = x1i; e.x1d = x1d;
    return e;
  endfunction

  function automatic ev_t ev_idle(logic [S-1:0] c);
    return mk(3'b000, c, '0, '0, '0, '0, 4'hF, 0, '0, '0, '0, '0, '0, '0);
  endfunction

  // Label events: tag bit0 -> (i0,d0), bit1 -> (i1,d1), lane 0 first.
  function automatic ev_t ev_lab(logic [2:0] tag, logic [S-1:0] c, i0, i1, logic [K-1:0] d0, d1);
    if (tag == 3'b111) return mk(tag, c, i0, i1, d0, d1, 4'hF, 2, C_LAB, i0, d0, C_LAB, i1, d1);
    if (tag == 3'b101) return mk(tag, c, i0, i1, d0, d1, 4'hF, 1, C_LAB, i0, d0, '0, '0, '0);
    return mk(3'b110, c, i0, i1, d0, d1, 4'hF, 1, C_LAB, i1, d1, '0, '0, '0);
  endfunction

  function automatic ev_t ev_tbl(logic [S-1:0] c, i0, i1, logic [K-1:0] d0, d1);
    return mk(3'b010, c, i0, i1, d0, d1, 4'hF, 2, C_TAB, i0, d0, C_TAB, i1, d1);
  endfunction

  function automatic logic [K-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive(input ev_t e);
    cur = e;
    tag_t1 = e.tag; cid = e.cid; index0_t1 = e.i0; index1_t1 = e.i1;
    data0_t1 = e.d0; data1_t1 = e.d1; class_en = e.cen;
  endtask

  // Advance one clock; then apply the event just sampled to the model.
  task automatic tick();
    int occ_start;
    exp_t x;
    @(posedge clk);
    #1;
    if (!rst) begin
      sb.delete();
      pending_pop = 0; exp_ovf = 0; exp_drop = 0; exp_done_seen = 0;
    end else begin
      occ_start = sb.size() + int'(pending_pop);
      pending_pop = 0;
      if (!exp_done_seen) begin
        if (cur.cid == S'(CC)) exp_done_seen = 1;
        else if (cur.n != 0) begin
          if (DEPTH - occ_start >= cur.n) begin
            x.cls = cur.c0; x.cid = cur.cid; x.idx = cur.x0i; x.data = cur.x0d; sb.push_back(x);
            if (cur.n == 2) begin
              x.cls = cur.c1; x.idx = cur.x1i; x.data = cur.x1d; sb.push_back(x);
            end
          end else begin
            exp_ovf = 1;
            exp_drop = (exp_drop + cur.n > 65535) ? 65535 : exp_drop + cur.n;
          end
        end
      end
    end
  endtask

  // Port monitor: runs mid-cycle, when inputs and outputs are both settled.
  always @(negedge clk) begin
    if (mon_en && rst) begin
      chk("out_valid", out_valid, sb.size() != 0);
      chk("overflow", overflow, exp_ovf);
      chk("drop_cnt", drop_cnt, exp_drop);
      chk("done", done, exp_done_seen && sb.size() == 0);
      if (sb.size() != 0) begin
        chk("out_last", out_last, exp_done_seen && sb.size() == 1);
        chk("out_class", out_class, sb[0].cls);
        chk("out_cid", out_cid, sb[0].cid);
        chk("out_index", out_index, sb[0].idx);
        chk("out_data", out_data, sb[0].data);
        if (out_ready) begin
          $display("pop cls=%0d cid=%0d idx=%0d data=%h last=%0b", out_class, out_cid,
                   out_index, out_data, out_last);
          void'(sb.pop_front());
          pending_pop = 1;
        end
      end
    end
  end

  task automatic drain(input int budget);
    out_ready = 1'b1;
    drive(ev_idle(cur.cid == S'(CC) ? 10'd1 : cur.cid));
    for (int i = 0; i < budget && sb.size() != 0; i++) tick();
    tick();
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    ev_t tbl[12];
    tbl[0]  = mk(3'b101, 1, 3, 0, 128'hA, 128'h0, 4'hF, 1, C_LAB, 3, 128'hA, '0, '0, '0);
    tbl[1]  = mk(3'b110, 1, 0, 7, 128'h0, 128'hB, 4'hF, 1, C_LAB, 7, 128'hB, '0, '0, '0);
    tbl[2]  = mk(3'b111, 1, 5, 6, 128'h55, 128'h66, 4'hF, 2, C_LAB, 5, 128'h55, C_LAB, 6, 128'h66);
    tbl[3]  = mk(3'b001, 1, 9, 9, 128'hC0, 128'hC1, 4'hF, 2, C_KEY, 0, 128'hC0, C_KEY, 1, 128'hC1);
    tbl[4]  = mk(3'b001, 1, 9, 9, 128'hC0, 128'hC1, 4'hD, 0, '0, '0, '0, '0, '0, '0);
    tbl[5]  = mk(3'b010, 2, 11, 12, 128'hE0, 128'hE1, 4'hF, 2, C_TAB, 11, 128'hE0, C_TAB, 12, 128'hE1);
    tbl[6]  = mk(3'b011, 2, 13, 14, 128'hF0, 128'hF1, 4'hF, 1, C_MSK, 0, 128'hF0, '0, '0, '0);
    tbl[7]  = mk(3'b100, 2, 1, 2, 128'h1, 128'h2, 4'hF, 0, '0, '0, '0, '0, '0, '0);
    tbl[8]  = mk(3'b000, 2, 1, 2, 128'h1, 128'h2, 4'hF, 0, '0, '0, '0, '0, '0, '0);
    tbl[9]  = mk(3'b010, 2, 1, 2, 128'h1, 128'h2, 4'hB, 0, '0, '0, '0, '0, '0, '0);
    tbl[10] = mk(3'b111, 2, 1, 2, 128'h1, 128'h2, 4'hE, 0, '0, '0, '0, '0, '0, '0);
    tbl[11] = mk(3'b011, 2, 1, 2, 128'h1, 128'h2, 4'h7, 0, '0, '0, '0, '0, '0, '0);

    // Reset
    drive(ev_idle(1));
    out_ready = 1'b1;
    tick(); tick();
    rst = 1'b1;
    mon_en = 1;
    chk("rst_valid", out_valid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_done", done, 0);

    // Decode / filter table, sink always ready
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i]);
      $display("event %0d tag=%b cen=%h", i, tbl[i].tag, tbl[i].cen);
      tick();
      chk("tbl_valid", out_valid, sb.size() != 0);
    end
    drain(20);
    chk("tbl_nodrop", drop_cnt, 0);

    // Overflow: 9 table events into a stalled 16-entry buffer
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive(ev_tbl(2, 10'(20 + 2 * i), 10'(21 + 2 * i), rnd128(), rnd128()));
      tick();
    end
    drive(ev_idle(2)); tick();
    chk("ovf_set", overflow, 1);
    chk("ovf_drop2", drop_cnt, 2);
    out_ready = 1'b1;                                   // pop while full: no credit
    drive(ev_lab(3'b101, 2, 40, 0, rnd128(), '0)); tick();
    out_ready = 1'b0;                                   // 15 held: pair refused whole
    drive(ev_tbl(2, 41, 42, rnd128(), rnd128())); tick();
    drive(ev_lab(3'b101, 2, 43, 0, rnd128(), '0)); tick();
    drive(ev_idle(2)); tick();
    chk("ovf_drop5", drop_cnt, 5);
    chk("ovf_full_valid", out_valid, 1);
    drain(60);

    // Back-to-back pushes with a toggling sink
    for (int i = 0; i < 12; i++) begin
      out_ready = i[0];
      drive(ev_lab(i[1] ? 3'b110 : 3'b101, 3, 10'(50 + i), 10'(70 + i), rnd128(), rnd128()));
      tick();
    end
    drain(40);

    // Mid-run reset with 5 entries buffered
    out_ready = 1'b0;
    drive(ev_lab(3'b111, 1, 1, 2, rnd128(), rnd128())); tick();
    drive(ev_lab(3'b111, 1, 3, 4, rnd128(), rnd128())); tick();
    drive(ev_lab(3'b101, 1, 5, 0, rnd128(), '0)); tick();
    drive(ev_idle(1)); tick();
    chk("pre_rst_valid", out_valid, 1);
    rst = 1'b0; tick();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_overflow", overflow, 0);
    chk("mid_rst_drop", drop_cnt, 0);
    rst = 1'b1; out_ready = 1'b1;
    drive(ev_lab(3'b101, 1, 9, 0, 128'h1234, '0)); tick();
    chk("post_rst_valid", out_valid, 1);
    drain(10);

    // End of run: cid==CC with 3 entries buffered
    out_ready = 1'b0;
    drive(ev_lab(3'b111, 1, 1, 2, rnd128(), rnd128())); tick();
    drive(ev_lab(3'b101, 2, 3, 0, rnd128(), '0)); tick();
    drive(mk(3'b011, 10'(CC), 0, 0, 128'hDEAD, 0, 4'hF, 1, C_MSK, 0, 128'hDEAD, '0, '0, '0)); tick();
    drive(ev_lab(3'b111, 1, 5, 6, rnd128(), rnd128())); tick();
    chk("eor_not_done", done, 0);
    drain(10);
    chk("eor_done", done, 1);
    tick(); tick();
    chk("eor_done_sticky", done, 1);
    chk("eor_valid_low", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
